decode_stage: RTL

//  ID stage of the 5-stage MIPS pipeline: holds the IF/ID register, decodes the instruction and

---
 rtl/decode_stage_pkg.sv | 58 +++++
 rtl/decode_stage_if.sv | 42 ++++
 rtl/decode_stage_id_decoder.sv | 110 +++++++++++
 rtl/decode_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared constants and types for the ID stage: opcodes, functs, ALU one-hot bit positions,
// operand-select and branch-type enums.
package decode_stage_pkg;

  localparam int ALUOP_W = 12;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

  localparam logic [4:0] REG_RA = 5'd31;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {SRC1_RS, SRC1_SA, SRC1_PC} src1_sel_e;
  typedef enum logic       {SRC2_RT, SRC2_IMM} src2_sel_e;
  typedef enum logic [2:0] {BR_NONE, BR_BEQ, BR_BNE, BR_J, BR_JR} br_type_e;

  function automatic logic [ALUOP_W-1:0] alu_onehot(input int idx);
    return ALUOP_W'(1) << idx;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, hazard-unit and ID/EX signals of the decode stage; master is the surrounding pipeline,
// slave is the decode stage itself.
interface decode_stage_if;
  import decode_stage_pkg::*;

  logic               fe_valid;
  logic [31:0]        fe_pc;
  logic [31:0]        fe_inst;
  logic               de_allowin;
  logic [4:0]         forward_rs;
  logic [4:0]         forward_rt;
  logic [31:0]        rs_data;
  logic [31:0]        rt_data;
  logic               stall;
  logic               br_taken;
  logic [31:0]        br_target;
  logic               de_valid;
  logic [31:0]        de_pc;
  logic [ALUOP_W-1:0] de_aluop;
  logic [31:0]        de_src1;
  logic [31:0]        de_src2;
  logic [4:0]         de_dest;
  logic               de_wen;
  logic               de_memread;
  logic               de_memwrite;
  logic [31:0]        de_store;

  modport master (
    output fe_valid, fe_pc, fe_inst, rs_data, rt_data, stall,
    input  de_allowin, forward_rs, forward_rt, br_taken, br_target,
    input  de_valid, de_pc, de_aluop, de_src1, de_src2, de_dest,
    input  de_wen, de_memread, de_memwrite, de_store
  );

  modport slave (
    input  fe_valid, fe_pc, fe_inst, rs_data, rt_data, stall,
    output de_allowin, forward_rs, forward_rt, br_taken, br_target,
    output de_valid, de_pc, de_aluop, de_src1, de_src2, de_dest,
    output de_wen, de_memread, de_memwrite, de_store
  );

endinterface

// File: rtl/decode_stage_id_decoder.sv
// Pure combinational MIPS decoder: instruction word -> ALU op, operand selects, immediates,
// destination, write/memory controls and branch type. Zero latency, no handshake.
module decode_stage_id_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0]        inst,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [ALUOP_W-1:0] aluop,
  output src1_sel_e          src1_sel,
  output src2_sel_e          src2_sel,
  output logic [31:0]        imm_val,
  output logic [31:0]        sa_ext,
  output logic [31:0]        br_off,
  output logic [25:0]        jidx,
  output logic [4:0]         dest,
  output logic               wen,
  output logic               memread,
  output logic               memwrite,
  output br_type_e           br_type
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] simm;

  assign op     = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign funct  = inst[5:0];
  assign imm    = inst[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign sa_ext = {27'b0, inst[10:6]};
  assign br_off = {simm[29:0], 2'b00};
  assign jidx   = inst[25:0];

  always_comb begin
    aluop    = '0;
    src1_sel = SRC1_RS;
    src2_sel = SRC2_RT;
    imm_val  = simm;
    dest     = '0;
    wen      = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    br_type  = BR_NONE;
    case (op)
      OP_SPECIAL: begin
        dest = rd;
        wen  = 1'b1;
        case (funct)
          FN_SLL:  begin aluop = alu_onehot(ALU_SLL); src1_sel = SRC1_SA; end
          FN_SRL:  begin aluop = alu_onehot(ALU_SRL); src1_sel = SRC1_SA; end
          FN_SRA:  begin aluop = alu_onehot(ALU_SRA); src1_sel = SRC1_SA; end
          FN_ADDU: aluop = alu_onehot(ALU_ADD);
          FN_SUBU: aluop = alu_onehot(ALU_SUB);
          FN_AND:  aluop = alu_onehot(ALU_AND);
          FN_OR:   aluop = alu_onehot(ALU_OR);
          FN_XOR:  aluop = alu_onehot(ALU_XOR);
          FN_NOR:  aluop = alu_onehot(ALU_NOR);
          FN_SLT:  aluop = alu_onehot(ALU_SLT);
          FN_SLTU: aluop = alu_onehot(ALU_SLTU);
          FN_JR:   begin dest = '0; wen = 1'b0; br_type = BR_JR; end
          default: begin dest = '0; wen = 1'b0; end
        endcase
      end
      OP_ADDIU: begin aluop = alu_onehot(ALU_ADD);  src2_sel = SRC2_IMM; dest = rt; wen = 1'b1; end
      OP_SLTI:  begin aluop = alu_onehot(ALU_SLT);  src2_sel = SRC2_IMM; dest = rt; wen = 1'b1; end
      OP_SLTIU: begin aluop = alu_onehot(ALU_SLTU); src2_sel = SRC2_IMM; dest = rt; wen = 1'b1; end
      OP_ANDI: begin
        aluop = alu_onehot(ALU_AND); src2_sel = SRC2_IMM; imm_val = {16'b0, imm};
        dest = rt; wen = 1'b1;
      end
      OP_ORI: begin
        aluop = alu_onehot(ALU_OR); src2_sel = SRC2_IMM; imm_val = {16'b0, imm};
        dest = rt; wen = 1'b1;
      end
      OP_XORI: begin
        aluop = alu_onehot(ALU_XOR); src2_sel = SRC2_IMM; imm_val = {16'b0, imm};
        dest = rt; wen = 1'b1;
      end
      OP_LUI: begin
        aluop = alu_onehot(ALU_LUI); src2_sel = SRC2_IMM; imm_val = {imm, 16'b0};
        dest = rt; wen = 1'b1;
      end
      OP_LW: begin
        aluop = alu_onehot(ALU_ADD); src2_sel = SRC2_IMM; dest = rt; wen = 1'b1; memread = 1'b1;
      end
      OP_SW:  begin aluop = alu_onehot(ALU_ADD); src2_sel = SRC2_IMM; memwrite = 1'b1; end
      OP_BEQ: br_type = BR_BEQ;
      OP_BNE: br_type = BR_BNE;
      OP_J:   br_type = BR_J;
      // Link value is computed by the ALU as pc + 8 so EX needs no special path.
      OP_JAL: begin
        br_type  = BR_J;
        aluop    = alu_onehot(ALU_ADD);
        src1_sel = SRC1_PC;
        src2_sel = SRC2_IMM;
        imm_val  = 32'd8;
        dest     = REG_RA;
        wen      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: IF/ID register, operand mux, branch resolution in ID, ID/EX register (1 cycle).
// Hazard stall freezes IF/ID, bubbles ID/EX and deasserts de_allowin.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic          clk,
  input  logic          resetn,
  decode_stage_if.slave io
);

  logic        ir_valid_q, ir_valid_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic [31:0] ir_inst_q, ir_inst_d;

  always_comb begin
    ir_valid_d = ir_valid_q;
    ir_pc_d    = ir_pc_q;
    ir_inst_d  = ir_inst_q;
    if (!io.stall) begin
      ir_valid_d = io.fe_valid;
      ir_pc_d    = io.fe_pc;
      ir_inst_d  = io.fe_inst;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ir_valid_q <= 1'b0;
      ir_pc_q    <= '0;
      ir_inst_q  <= '0;
    end else begin
      ir_valid_q <= ir_valid_d;
      ir_pc_q    <= ir_pc_d;
      ir_inst_q  <= ir_inst_d;
    end
  end

  logic [4:0]         dec_rs, dec_rt, dec_dest;
  logic [ALUOP_W-1:0] dec_aluop;
  src1_sel_e          dec_src1_sel;
  src2_sel_e          dec_src2_sel;
  logic [31:0]        dec_imm, dec_sa_ext, dec_br_off;
  logic [25:0]        dec_jidx;
  logic               dec_wen, dec_memread, dec_memwrite;
  br_type_e           dec_br_type;

  decode_stage_id_decoder u_id_decoder (
    .inst     (ir_inst_q),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .aluop    (dec_aluop),
    .src1_sel (dec_src1_sel),
    .src2_sel (dec_src2_sel),
    .imm_val  (dec_imm),
    .sa_ext   (dec_sa_ext),
    .br_off   (dec_br_off),
    .jidx     (dec_jidx),
    .dest     (dec_dest),
    .wen      (dec_wen),
    .memread  (dec_memread),
    .memwrite (dec_memwrite),
    .br_type  (dec_br_type)
  );

  logic [31:0] src1, src2, pc_plus4, br_target;
  logic        br_cond, issue;

  always_comb begin
    src1 = io.rs_data;
    case (dec_src1_sel)
      SRC1_SA: src1 = dec_sa_ext;
      SRC1_PC: src1 = ir_pc_q;
      default: ;
    endcase
  end

  assign src2     = (dec_src2_sel == SRC2_IMM) ? dec_imm : io.rt_data;
  assign pc_plus4 = ir_pc_q + 32'd4;

  always_comb begin
    br_cond   = 1'b0;
    br_target = pc_plus4 + dec_br_off;
    case (dec_br_type)
      BR_BEQ: br_cond = (io.rs_data == io.rt_data);
      BR_BNE: br_cond = (io.rs_data != io.rt_data);
      BR_J:   begin br_cond = 1'b1; br_target = {pc_plus4[31:28], dec_jidx, 2'b00}; end
      BR_JR:  begin br_cond = 1'b1; br_target = io.rs_data; end
      default: ;
    endcase
  end

  // Under stall the forwarded operands are stale, so neither redirect nor issue.
  assign issue         = ir_valid_q & ~io.stall;
  assign io.br_taken   = issue & br_cond;
  assign io.br_target  = br_target;
  assign io.de_allowin = ~io.stall;
  assign io.forward_rs = ir_valid_q ? dec_rs : 5'd0;
  assign io.forward_rt = ir_valid_q ? dec_rt : 5'd0;

  logic               de_valid_q, de_valid_d;
  logic [31:0]        de_pc_q, de_pc_d;
  logic [ALUOP_W-1:0] de_aluop_q, de_aluop_d;
  logic [31:0]        de_src1_q, de_src1_d;
  logic [31:0]        de_src2_q, de_src2_d;
  logic [4:0]         de_dest_q, de_dest_d;
  logic               de_wen_q, de_wen_d;
  logic               de_memread_q, de_memread_d;
  logic               de_memwrite_q, de_memwrite_d;
  logic [31:0]        de_store_q, de_store_d;

  always_comb begin
    de_valid_d    = issue;
    de_wen_d      = issue & dec_wen & (dec_dest != 5'd0);
    de_memread_d  = issue & dec_memread;
    de_memwrite_d = issue & dec_memwrite;
    de_pc_d       = de_pc_q;
    de_aluop_d    = de_aluop_q;
    de_src1_d     = de_src1_q;
    de_src2_d     = de_src2_q;
    de_dest_d     = de_dest_q;
    de_store_d    = de_store_q;
    if (issue) begin
      de_pc_d    = ir_pc_q;
      de_aluop_d = dec_aluop;
      de_src1_d  = src1;
      de_src2_d  = src2;
      de_dest_d  = dec_dest;
      de_store_d = io.rt_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      de_valid_q    <= 1'b0;
      de_pc_q       <= '0;
      de_aluop_q    <= '0;
      de_src1_q     <= '0;
      de_src2_q     <= '0;
      de_dest_q     <= '0;
      de_wen_q      <= 1'b0;
      de_memread_q  <= 1'b0;
      de_memwrite_q <= 1'b0;
      de_store_q    <= '0;
    end else begin
      de_valid_q    <= de_valid_d;
      de_pc_q       <= de_pc_d;
      de_aluop_q    <= de_aluop_d;
      de_src1_q     <= de_src1_d;
      de_src2_q     <= de_src2_d;
      de_dest_q     <= de_dest_d;
      de_wen_q      <= de_wen_d;
      de_memread_q  <= de_memread_d;
      de_memwrite_q <= de_memwrite_d;
      de_store_q    <= de_store_d;
    end
  end

  assign io.de_valid    = de_valid_q;
  assign io.de_pc       = de_pc_q;
  assign io.de_aluop    = de_aluop_q;
  assign io.de_src1     = de_src1_q;
  assign io.de_src2     = de_src2_q;
  assign io.de_dest     = de_dest_q;
  assign io.de_wen      = de_wen_q;
  assign io.de_memread  = de_memread_q;
  assign io.de_memwrite = de_memwrite_q;
  assign io.de_store    = de_store_q;

endmodule
